// File: rtl/prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prbs_checker                                                 |
// | Description : PRBS31 (x^31+x^28+1, inverted) word checker with            |
// |               SEEK/SYNC/LOCKED synchronisation and saturating error        |
// |               counters. Define PRBS_CHECKER_BIT_CNT_EN to build the        |
// |               errored-bit counter; otherwise err_bit_cnt reads zero.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prbs_checker #(
    parameter int WIDTH       = 31,
    parameter int LOCK_THRESH = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [31:0]      err_word_cnt,
    output logic [31:0]      err_bit_cnt
);

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]  c_LOCK_THRESH = 8'(LOCK_THRESH);
    localparam logic [7:0]  c_LOSS_THRESH = 8'(LOSS_THRESH);
    localparam logic [31:0] c_CNT_MAX     = 32'hFFFF_FFFF;

    // One full word of the generator: 31 serial shifts collapse to this pair of XORs.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        n[30:3] = s[30:3] ^ s[27:0];
        n[2:0]  = s[2:0] ^ n[30:28];
        return n;
    endfunction

    state_t           r_fsm;
    logic [WIDTH-1:0] r_state;
    logic [7:0]       r_good_cnt;
    logic [7:0]       r_bad_cnt;
    logic             r_locked;
    logic             r_err;
    logic [31:0]      r_err_word_cnt;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_expect;
    logic             w_match;
    logic             w_seedable;
    logic [7:0]       w_good_inc;
    logic [7:0]       w_bad_inc;
    logic             w_word_err;

    assign w_step     = step(r_state);
    assign w_expect   = ~w_step;
    assign w_match    = (din == w_expect);
    assign w_seedable = (din != {WIDTH{1'b1}});
    assign w_good_inc = r_good_cnt + 8'd1;
    assign w_bad_inc  = r_bad_cnt + 8'd1;
    assign w_word_err = din_valid && (r_fsm == LOCKED) && !w_match;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fsm      <= SEEK;
            r_state    <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_good_cnt <= 8'd0;
            r_bad_cnt  <= 8'd0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (din_valid) begin
                case (r_fsm)
                    SEEK: begin
                        if (w_seedable) begin
                            r_state    <= ~din;
                            r_good_cnt <= 8'd0;
                            r_fsm      <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (w_match) begin
                            r_state    <= ~din;
                            r_good_cnt <= w_good_inc;
                            if (w_good_inc == c_LOCK_THRESH) begin
                                r_fsm     <= LOCKED;
                                r_locked  <= 1'b1;
                                r_bad_cnt <= 8'd0;
                            end
                        end else if (w_seedable) begin
                            r_state    <= ~din;
                            r_good_cnt <= 8'd0;
                        end else begin
                            r_good_cnt <= 8'd0;
                            r_fsm      <= SEEK;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: received words never reload the state once locked.
                        r_state <= w_step;
                        if (w_match) begin
                            r_bad_cnt <= 8'd0;
                        end else begin
                            r_err     <= 1'b1;
                            r_bad_cnt <= w_bad_inc;
                            if (w_bad_inc == c_LOSS_THRESH) begin
                                r_fsm    <= SEEK;
                                r_locked <= 1'b0;
                            end
                        end
                    end
                    default: r_fsm <= SEEK;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr_cnt) begin
            r_err_word_cnt <= 32'd0;
        end else if (w_word_err && (r_err_word_cnt != c_CNT_MAX)) begin
            r_err_word_cnt <= r_err_word_cnt + 32'd1;
        end
    end

`ifdef PRBS_CHECKER_BIT_CNT_EN
    logic [WIDTH-1:0] w_diff;
    logic [5:0]       w_popcnt;
    logic [32:0]      w_bit_sum;
    logic [31:0]      r_err_bit_cnt;

    assign w_diff = din ^ w_expect;

    always_comb begin
        w_popcnt = 6'd0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + 6'(w_diff[i]);
        end
    end

    assign w_bit_sum = {1'b0, r_err_bit_cnt} + 33'(w_popcnt);

    always_ff @(posedge clk) begin
        if (!rstn || clr_cnt) begin
            r_err_bit_cnt <= 32'd0;
        end else if (w_word_err) begin
            r_err_bit_cnt <= w_bit_sum[32] ? c_CNT_MAX : w_bit_sum[31:0];
        end
    end

    assign err_bit_cnt = r_err_bit_cnt;
`else
    assign err_bit_cnt = 32'd0;
`endif

    assign locked       = r_locked;
    assign err          = r_err;
    assign err_word_cnt = r_err_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_prbs_checker                                              |
// | Description : Directed plus randomised bench for prbs_checker against a    |
// |               behavioural reference model of the sync/lock rules.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prbs_checker;

    localparam int LOCK_THRESH = 16;
    localparam int LOSS_THRESH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [30:0] din = '0;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err;
    logic [31:0] err_word_cnt;
    logic [31:0] err_bit_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    prbs_checker #(
        .WIDTH       (31),
        .LOCK_THRESH (LOCK_THRESH),
        .LOSS_THRESH (LOSS_THRESH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .din          (din),
        .din_valid    (din_valid),
        .clr_cnt      (clr_cnt),
        .locked       (locked),
        .err          (err),
        .err_word_cnt (err_word_cnt),
        .err_bit_cnt  (err_bit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: generator step built bit by bit from the recurrence.
    function automatic logic [30:0] ref_step(input logic [30:0] s);
        logic [30:0] n;
        for (int i = 30; i >= 0; i--) begin
            n[i] = s[i] ^ ((i >= 3) ? s[i-3] : n[i+28]);
        end
        return n;
    endfunction

    int          m_mode;  // 0 seek, 1 sync, 2 locked
    logic [30:0] m_state;
    int          m_good;
    int          m_bad;
    logic        m_locked;
    logic        m_err;
    longint      m_wcnt;
    longint      m_bcnt;
    logic [30:0] gen;

    task automatic model_reset();
        m_mode = 0; m_state = 31'h1; m_good = 0; m_bad = 0;
        m_locked = 1'b0; m_err = 1'b0; m_wcnt = 0; m_bcnt = 0;
    endtask

    task automatic model_clock(input logic [30:0] d, input logic v, input logic c, input logic r);
        logic [30:0] exp_w;
        int          pc;
        bit          inc;
        if (!r) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        inc   = 0;
        pc    = 0;
        exp_w = ~ref_step(m_state);
        if (v) begin
            if (m_mode == 0) begin
                if (~d != 31'h0) begin m_state = ~d; m_good = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == exp_w) begin
                    m_state = ~d;
                    m_good  = m_good + 1;
                    if (m_good == LOCK_THRESH) begin m_mode = 2; m_locked = 1'b1; m_bad = 0; end
                end else if (~d != 31'h0) begin
                    m_state = ~d; m_good = 0;
                end else begin
                    m_mode = 0; m_good = 0;
                end
            end else begin
                m_state = ref_step(m_state);
                if (d == exp_w) begin
                    m_bad = 0;
                end else begin
                    m_err = 1'b1;
                    inc   = 1;
                    pc    = $countones(d ^ exp_w);
                    m_bad = m_bad + 1;
                    if (m_bad == LOSS_THRESH) begin m_mode = 0; m_locked = 1'b0; end
                end
            end
        end
        if (c) begin
            m_wcnt = 0; m_bcnt = 0;
        end else if (inc) begin
            m_wcnt = (m_wcnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_wcnt + 1;
            m_bcnt = (m_bcnt + pc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bcnt + pc;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic apply(input logic [30:0] d, input logic v, input logic c, input logic r);
        logic [31:0] exp_bits;
        @(negedge clk);
        din = d; din_valid = v; clr_cnt = c; rstn = r;
        @(posedge clk);
        model_clock(d, v, c, r);
        #1;
`ifdef PRBS_CHECKER_BIT_CNT_EN
        exp_bits = m_bcnt[31:0];
`else
        exp_bits = 32'h0;
`endif
        check("locked", {31'h0, locked}, {31'h0, m_locked});
        check("err", {31'h0, err}, {31'h0, m_err});
        check("err_word_cnt", err_word_cnt, m_wcnt[31:0]);
        check("err_bit_cnt", err_bit_cnt, exp_bits);
    endtask

    task automatic next_word(output logic [30:0] w);
        gen = ref_step(gen);
        w   = ~gen;
    endtask

    task automatic send_clean(input int n, input bit toggle);
        logic [30:0] w;
        for (int i = 0; i < n; i++) begin
            if (toggle && (i % 2 == 1)) begin
                apply(31'($urandom), 1'b0, 1'b0, 1'b1);
            end else begin
                next_word(w);
                apply(w, 1'b1, 1'b0, 1'b1);
            end
        end
    endtask

    task automatic send_mask(input logic [30:0] mask, input logic c);
        logic [30:0] w;
        next_word(w);
        apply(w ^ mask, 1'b1, c, 1'b1);
    endtask

    initial begin
        logic [30:0] w;
        logic        v;
        model_reset();
        gen = 31'h1;

        apply(31'h0, 1'b0, 1'b0, 1'b0);
        apply(31'h0, 1'b1, 1'b1, 1'b0);

        // Acquire lock from the seed-1 generator; lock appears after word 17.
        send_clean(20, 1'b0);
        check("locked_after_20", {31'h0, locked}, 32'h1);

        send_mask(31'h1, 1'b0);
        send_clean(5, 1'b0);

        apply(31'h0, 1'b0, 1'b1, 1'b1);
        send_mask(31'h0000_0124, 1'b0);
        send_clean(3, 1'b0);

        for (int i = 0; i < 4; i++) begin
            next_word(w);
            apply(31'h0, 1'b1, 1'b0, 1'b1);
        end
        check("lost_after_zeros", {31'h0, locked}, 32'h0);

        for (int i = 0; i < 5; i++) begin
            next_word(w);
            apply(31'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
        end

        send_clean(20, 1'b0);
        send_clean(12, 1'b1);

        send_mask(31'h4000_0003, 1'b1);
        send_clean(3, 1'b0);
        send_mask(31'h0000_0010, 1'b0);

        next_word(w);
        apply(w, 1'b1, 1'b0, 1'b0);
        check("reset_in_locked", {31'h0, locked}, 32'h0);
        send_clean(20, 1'b0);

        // Randomised traffic: gaps, sparse bit errors, error bursts, clears, resets.
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (!v) begin
                apply(31'($urandom), 1'b0, ($urandom_range(0, 31) == 0), 1'b1);
            end else begin
                next_word(w);
                if ($urandom_range(0, 11) == 0) w = w ^ 31'($urandom);
                else if ($urandom_range(0, 15) == 0) w = w ^ (31'h1 << $urandom_range(0, 30));
                apply(w, 1'b1, ($urandom_range(0, 31) == 0), ($urandom_range(0, 249) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 31: data word width; only 31 is supported, because one word carries the full PRBS state.
REQ-002 SHALL have parameter LOCK_THRESH, default 16: consecutive matching words, after the seed word, needed to declare lock; legal range 1..255.
REQ-003 SHALL have parameter LOSS_THRESH, default 4: consecutive errored words while locked that cause loss of lock; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port din, input, WIDTH: received PRBS word (x^31+x^28+1 generator output, inverted state).
REQ-007 SHALL have port din_valid, input, 1: din is accepted this cycle.
REQ-008 SHALL have port clr_cnt, input, 1: synchronous clear of both error counters.
REQ-009 SHALL have port locked, output, 1: checker is synchronised.
REQ-010 SHALL have port err, output, 1: one-cycle pulse per errored word while locked.
REQ-011 SHALL have port err_word_cnt, output, 32: count of errored words.
REQ-012 SHALL have port err_bit_cnt, output, 32: count of errored bits.

Function
REQ-013 Step function, with s the 31-bit state: n[30:3] = s[30:3] XOR s[27:0], then n[2:0] = s[2:0] XOR n[30:28].
REQ-014 The expected word for the next accepted input SHALL be the bitwise inverse of step(state).
REQ-015 The FSM SHALL have states SEEK, SYNC and LOCKED; no state or counter changes when din_valid=0.
REQ-016 SEEK, on an accepted word with ~din nonzero: state <= ~din, good_cnt <= 0, go to SYNC.
REQ-017 SEEK, on an accepted word with ~din zero (din = 31'h7FFFFFFF): stay in SEEK.
REQ-018 SYNC, on a matching word: state <= ~din and good_cnt increments.
REQ-019 SYNC: when good_cnt reaches LOCK_THRESH, go to LOCKED.
REQ-020 SYNC, on a mismatching word: reseed as in SEEK (REQ-016/REQ-017) in the same cycle; no error is counted.
REQ-021 LOCKED, on a matching word: state <= step(state) and bad_cnt <= 0.
REQ-022 LOCKED, on a mismatching word: state <= step(state) (the received word is not reloaded), err pulses, err_word_cnt increments, err_bit_cnt adds popcount(din XOR expected), and bad_cnt increments.
REQ-023 LOCKED: when bad_cnt reaches LOSS_THRESH, go to SEEK and deassert locked; the word that triggers this is still counted.
REQ-024 locked, err and the counters SHALL be registered and reflect an accepted word exactly one cycle after acceptance.
REQ-025 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-026 clr_cnt=1 SHALL zero both counters; when clr_cnt and an increment occur in the same cycle, the clear wins (result 0).
REQ-027 clr_cnt SHALL NOT affect the FSM, state, locked or err.

Reset
REQ-028 When rstn=0 at a clock edge: FSM <= SEEK, state <= 31'h1, good_cnt and bad_cnt <= 0, locked <= 0, err <= 0, err_word_cnt and err_bit_cnt <= 0.
REQ-029 Reset SHALL override din_valid and clr_cnt, including during LOCKED.

Configuration
REQ-030 Macro PRBS_CHECKER_BIT_CNT_EN defined: the popcount logic and err_bit_cnt register are compiled in, behaving as in REQ-022/025/026.
REQ-031 Macro PRBS_CHECKER_BIT_CNT_EN undefined: err_bit_cnt is driven constant 32'h0, no popcount logic exists, and the port remains present.

Verification
REQ-032 Reset, then 20 clean words with valid every cycle from a generator seeded 31'h1 (first word 31'h7FFFFFF6) -> locked=1 one cycle after the 17th word; err never pulses; both counters 0.
REQ-033 Locked, bit 0 of one word flipped -> err high for exactly one cycle; err_word_cnt=1, err_bit_cnt=1; locked stays 1; the following clean words produce no error.
REQ-034 Locked, one word with 3 bits flipped -> err_word_cnt=1, err_bit_cnt=3; with the macro undefined, err_bit_cnt=0.
REQ-035 Locked, four consecutive words 31'h0 -> err_word_cnt=4; locked=0 one cycle after the 4th word.
REQ-035a Locked, then 31'h7FFFFFFF held -> the FSM stays in SEEK.
REQ-036 Locked, din_valid toggling 1/0 with clean words -> no errors.
REQ-036a Locked, rstn=0 for one cycle -> locked=0 and counters 0 on the next cycle.
REQ-036b clr_cnt asserted with a concurrent error -> counters read 0.
